clk_enable_gen: RTL and testbench

//   Multi-channel clock-enable (strobe) generator. Each channel emits a one-cycle enable

---
 rtl/clk_enable_gen_if.sv | 22 ++
 rtl/clk_enable_gen.sv | 142 ++++++++++++++
 tb/tb_clk_enable_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_gen_if.sv
// clk_enable_gen_if
//   Configuration request port for clk_enable_gen. The requester (master) holds
//   valid/chan/div until it sees ready. The generator (slave) answers with ready
//   (accepting) and a one-cycle err pulse for a rejected request.
//   Signals:
//     valid  request valid                    (master -> slave)
//     chan   target channel index, 4 bits     (master -> slave)
//     div    new divisor, CNT_W bits          (master -> slave)
//     ready  port can accept a request        (slave -> master)
//     err    one-cycle reject pulse           (slave -> master)
interface clk_enable_gen_if #(
    parameter int CNT_W = 20
);
    logic             valid;
    logic             ready;
    logic [3:0]       chan;
    logic [CNT_W-1:0] div;
    logic             err;

    modport master (output valid, chan, div, input  ready, err);
    modport slave  (input  valid, chan, div, output ready, err);
endinterface

// File: rtl/clk_enable_gen.sv
// clk_enable_gen
//   Multi-channel clock-enable (strobe) generator. Each channel emits a one-cycle
//   enable pulse every DIV clocks. DIV is reprogrammable per channel through the
//   cfg port; a new divisor is committed at the channel's next period boundary
//   (or immediately when run is low), so no period is ever cut short.
//   Ports:
//     clk     clock
//     reset   synchronous, active-high reset
//     run     global count enable; 0 clears all counters and enables
//     cfg     configuration port (clk_enable_gen_if, slave side)
//     enable  per-channel registered one-cycle strobe
//     square  (only with CLK_EN_GEN_SQUARE_EN) per-channel 50% square wave,
//             toggling at every wrap, period 2*DIV
//   Optional feature macro: CLK_EN_GEN_SQUARE_EN
module clk_enable_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    clk_enable_gen_if.slave     cfg,
`ifdef CLK_EN_GEN_SQUARE_EN
    output logic [CHANNELS-1:0] square,
`endif
    output logic [CHANNELS-1:0] enable
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       stage_chan_reg, stage_chan_next;
    logic [CNT_W-1:0] stage_div_reg, stage_div_next;
    logic             err_reg, err_next;
    logic             commit;

    logic [CHANNELS-1:0] wrap;      // channel finishes its period on this edge
    logic [CHANNELS-1:0] chan_hit;  // channel is the target of the staged request
    logic                wrap_sel;

    assign wrap_sel  = |(wrap & chan_hit);
    assign cfg.ready = (state_reg == IDLE);
    assign cfg.err   = err_reg;

    // ------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            stage_chan_reg <= '0;
            stage_div_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            stage_chan_reg <= stage_chan_next;
            stage_div_reg  <= stage_div_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        stage_chan_next = stage_chan_reg;
        stage_div_next  = stage_div_reg;
        err_next        = 1'b0;
        commit          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg.valid) begin
                    // Channel index is widened so CHANNELS==16 compares correctly.
                    if (cfg.div == '0 || {1'b0, cfg.chan} >= 5'(CHANNELS)) begin
                        err_next = 1'b1;
                    end else begin
                        stage_chan_next = cfg.chan;
                        stage_div_next  = cfg.div;
                        state_next      = PEND;
                    end
                end
            end
            PEND: begin
                // Commit on the target's wrap, or at once while counting is stopped.
                if (!run || wrap_sel) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] div_reg;
            logic             en_reg;
            logic             sq_reg;

            assign chan_hit[gi] = (stage_chan_reg == 4'(gi));
            assign wrap[gi]     = run && (cnt_reg == div_reg - CNT_W'(1));
            assign enable[gi]   = en_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                    div_reg <= CNT_W'(DEFAULT_DIV);
                    en_reg  <= 1'b0;
                    sq_reg  <= 1'b0;
                end else begin
                    // The wrap on a commit edge still uses the old divisor, so the
                    // finishing period keeps its pulse; the new one applies next.
                    if (commit && chan_hit[gi])
                        div_reg <= stage_div_reg;
                    if (!run) begin
                        cnt_reg <= '0;
                        en_reg  <= 1'b0;
                        sq_reg  <= 1'b0;
                    end else if (wrap[gi]) begin
                        cnt_reg <= '0;
                        en_reg  <= 1'b1;
                        sq_reg  <= ~sq_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        en_reg  <= 1'b0;
                    end
                end
            end

`ifdef CLK_EN_GEN_SQUARE_EN
            assign square[gi] = sq_reg;
`else
            logic unused_sq;
            assign unused_sq = sq_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen
//   Directed bench for clk_enable_gen (CHANNELS=4, CNT_W=20, DEFAULT_DIV=16).
//   Inputs change and outputs are sampled 1 time unit after each rising edge;
//   k below counts rising edges since run was last raised.
module tb_clk_enable_gen;

    localparam int CH    = 4;
    localparam int CNT_W = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [CH-1:0] enable;
`ifdef CLK_EN_GEN_SQUARE_EN
    logic [CH-1:0] square;
`endif

    int total = 0;
    int bad   = 0;

    clk_enable_gen_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_enable_gen #(
        .CHANNELS    (CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .cfg    (cfg_if),
`ifdef CLK_EN_GEN_SQUARE_EN
        .square (square),
`endif
        .enable (enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic req(input logic [3:0] ch, input logic [CNT_W-1:0] dv);
        cfg_if.valid = 1'b1;
        cfg_if.chan  = ch;
        cfg_if.div   = dv;
    endtask

    logic [CH-1:0] e;

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        cfg_if.valid = 1'b0;
        cfg_if.chan  = '0;
        cfg_if.div   = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_en", 32'(enable), 0);
        chk("rst_ready", 32'(cfg_if.ready), 1);
        chk("rst_err", 32'(cfg_if.err), 0);
`ifdef CLK_EN_GEN_SQUARE_EN
        chk("rst_sq", 32'(square), 0);
`endif
        reset = 1'b0;
        tick();
        chk("idle_en", 32'(enable), 0);

        // Defaults: all channels pulse at 16, 32, 48
        run = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            e = (k % 16 == 0) ? 4'hF : 4'h0;
            chk("en_def", 32'(enable), 32'(e));
        end

        // Restart; program ch1 div=5 while cnt==7
        run = 1'b0;
        tick();
        chk("en_stop", 32'(enable), 0);
        run = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            e = (k % 16 == 0) ? 4'hF : 4'h0;
            e[1] = (k >= 16) && ((k - 16) % 5 == 0);
            chk("en_ch1", 32'(enable), 32'(e));
            chk("rdy_ch1", 32'(cfg_if.ready), (k >= 8 && k <= 15) ? 0 : 1);
            if (k == 7) req(4'd1, 20'd5);
            if (k == 8) cfg_if.valid = 1'b0;
        end

        // Rejected requests
        req(4'd0, 20'd0);
        tick();
        chk("err_div0", 32'(cfg_if.err), 1);
        chk("err_div0_rdy", 32'(cfg_if.ready), 1);
        cfg_if.valid = 1'b0;
        tick();
        chk("err_div0_end", 32'(cfg_if.err), 0);
        req(4'(CH), 20'd3);
        tick();
        chk("err_chan", 32'(cfg_if.err), 1);
        cfg_if.valid = 1'b0;
        tick();
        chk("err_chan_end", 32'(cfg_if.err), 0);
        chk("err_chan_rdy", 32'(cfg_if.ready), 1);

        // Restart: divisors intact; program ch2 div=1; stray request in PEND ignored
        run = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            e = (k % 16 == 0) ? 4'hF : 4'h0;
            e[1] = (k % 5 == 0);
            e[2] = (k % 16 == 0) || (k >= 32);
            chk("en_ch2", 32'(enable), 32'(e));
            chk("rdy_ch2", 32'(cfg_if.ready), (k >= 17 && k <= 31) ? 0 : 1);
            if (k == 16) req(4'd2, 20'd1);
            if (k == 17) cfg_if.valid = 1'b0;
            if (k == 20) req(4'd3, 20'd7);
            if (k == 21) cfg_if.valid = 1'b0;
        end

        // run low mid-count, then restart
        run = 1'b0;
        tick();
        chk("en_run0", 32'(enable), 0);
        run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = (k == 16) ? 4'hF : 4'h0;
            e[1] = (k % 5 == 0);
            e[2] = 1'b1;
            chk("en_rerun", 32'(enable), 32'(e));
        end

        // Config while stopped commits on the next edge
        run = 1'b0;
        tick();
        req(4'd3, 20'd9);
        tick();
        chk("rdy_stop_pend", 32'(cfg_if.ready), 0);
        cfg_if.valid = 1'b0;
        tick();
        chk("rdy_stop_done", 32'(cfg_if.ready), 1);
        run = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            e[0] = (k % 16 == 0);
            e[1] = (k % 5 == 0);
            e[2] = 1'b1;
            e[3] = (k % 9 == 0);
            chk("en_ch3", 32'(enable), 32'(e));
        end

        // Reset while a request is pending
        req(4'd0, 20'd3);
        tick();
        chk("rdy_pend", 32'(cfg_if.ready), 0);
        cfg_if.valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst2_ready", 32'(cfg_if.ready), 1);
        chk("rst2_en", 32'(enable), 0);
        chk("rst2_err", 32'(cfg_if.err), 0);
`ifdef CLK_EN_GEN_SQUARE_EN
        chk("rst2_sq", 32'(square), 0);
`endif
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            e = (k % 16 == 0) ? 4'hF : 4'h0;
            chk("en_post_rst", 32'(enable), 32'(e));
        end

`ifdef CLK_EN_GEN_SQUARE_EN
        // Square output: ch0 div=4 -> 4 high / 4 low
        run = 1'b0;
        tick();
        chk("sq_run0", 32'(square), 0);
        req(4'd0, 20'd4);
        tick();
        cfg_if.valid = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("sq0", 32'(square[0]), ((k / 4) % 2 == 1) ? 1 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
